// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths and FSM state encoding for the fetch sequencer.
//   PC_W        - program counter width
//   IMM_W       - branch immediate width
//   JIDX_W      - J-type index field width
//   INSTR_BYTES - sequential PC increment
package pc_seq_pkg;
  localparam int PC_W        = 32;
  localparam int IMM_W       = 16;
  localparam int JIDX_W      = 26;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    ISSUE  = 2'd1,
    SQUASH = 2'd2,
    STALL  = 2'd3
  } state_e;
endpackage

// File: rtl/pc_fetch_sequencer_next_pc_target.sv
// next_pc_target: combinational next-PC arithmetic.
//   pc            in  current PC
//   branch_taken  in  branch redirect request
//   jump          in  jump redirect request (wins over branch)
//   branch_base   in  PC+4 of the resolving branch/jump
//   branch_offset in  branch immediate
//   jump_index    in  J-type index
//   pc_plus4      out pc + 4, mod 2^32
//   target        out selected redirect target
//   redirect      out jump | branch_taken
module next_pc_target
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0]   pc,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [PC_W-1:0]   branch_base,
  input  logic [IMM_W-1:0]  branch_offset,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [PC_W-1:0]   pc_plus4,
  output logic [PC_W-1:0]   target,
  output logic              redirect
);
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;

  assign pc_plus4 = pc + PC_W'(INSTR_BYTES);
  // word offset: sign-extend and scale by 4
  assign br_tgt   = branch_base +
                    {{(PC_W-IMM_W-2){branch_offset[IMM_W-1]}}, branch_offset, 2'b00};
  assign j_tgt    = {branch_base[PC_W-1:PC_W-4], jump_index, 2'b00};
  assign target   = jump ? j_tgt : br_tgt;
  assign redirect = jump | branch_taken;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC register plus fetch FSM driving a req/ready
// instruction-memory handshake.
//   clk, rst_n          clock / async active-low reset
//   imem_req/addr/ready memory handshake; req+addr held until ready
//   stall               hold fetch (honoured only between transactions)
//   branch_*, jump*     redirect sources; jump wins
//   pc, pc_plus4        current fetch PC and its successor
//   fetch_valid         returned instruction is valid for IF/ID
//   flush               kill IF/ID contents this cycle
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_base,
  input  logic [IMM_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              fetch_valid,
  output logic              flush
);
  state_e          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] redir_pc, redir_nxt;
  logic [PC_W-1:0] target;
  logic            redirect;

  next_pc_target u_tgt (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .pc_plus4      (pc_plus4),
    .target        (target),
    .redirect      (redirect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_nxt;
    end
  end

  // pc only moves on completion or while idle in STALL, so the address
  // seen by memory is always pc and stays stable through a wait.
  assign imem_addr = pc;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    redir_nxt   = redir_pc;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    unique case (state)
      BOOT: state_nxt = ISSUE;  // stall and redirects ignored here
      ISSUE: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect) begin
            flush  = 1'b1;
            pc_nxt = target;
          end else begin
            fetch_valid = 1'b1;
            pc_nxt      = pc_plus4;
          end
          state_nxt = stall ? STALL : ISSUE;
        end else if (redirect) begin
          // request can't be withdrawn: remember where to go and let the
          // stale fetch drain in SQUASH
          flush     = 1'b1;
          redir_nxt = target;
          state_nxt = SQUASH;
        end
      end
      SQUASH: begin
        imem_req = 1'b1;
        if (redirect) begin
          flush     = 1'b1;
          redir_nxt = target;
        end
        if (imem_ready) begin
          pc_nxt    = redirect ? target : redir_pc;  // newest redirect wins
          state_nxt = stall ? STALL : ISSUE;
        end
      end
      STALL: begin
        if (redirect) begin
          flush  = 1'b1;
          pc_nxt = target;
        end
        if (!stall) state_nxt = ISSUE;
      end
      default: state_nxt = BOOT;
    endcase
  end
endmodule
